irom_loader: RTL

IROM_LOADER -- requirements
Module: irom_loader

---
 rtl/irom_loader_if.sv | 10 +
 rtl/irom_loader.sv | 104 ++++++++++
 2 files changed

// File: rtl/irom_loader_if.sv
// Image-ROM bus between irom_loader (master) and the ROM macro (slave).
// IROM_EN is active-low and drives the ROM CEN pin directly.
interface irom_loader_if;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;

  modport master (output IROM_EN, output IROM_A, input IROM_Q);
  modport slave  (input IROM_EN, input IROM_A, output IROM_Q);
endinterface

// File: rtl/irom_loader.sv
// irom_loader: streams a 64-byte image out of a fixed-latency ROM into a
// local 64x8 buffer (row-major, address = row*8+col) with a registered read port.
// Optional running byte checksum is enabled by defining LOADER_CHECKSUM_EN;
// without it the checksum port is tied to zero.
module irom_loader #(
  parameter int RD_LAT = 2              // ROM read latency in clock edges, 1..4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  irom_loader_if.master rom,
  input  logic [5:0]    rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state;
  // Stage 0 is the address on the ROM bus this cycle; stage k is the address
  // issued k cycles earlier. The oldest stage lines up with IROM_Q.
  logic [RD_LAT-1:0]      vld_pipe;
  logic [RD_LAT-1:0][5:0] addr_pipe;
  logic [7:0]             mem [64];

  logic       launch;
  logic       cap;
  logic       cap_last;
  logic [5:0] cap_addr;

  assign launch   = start && (state == IDLE || state == DONE);
  assign cap      = vld_pipe[RD_LAT-1];
  assign cap_addr = addr_pipe[RD_LAT-1];
  assign cap_last = cap && (cap_addr == 6'd63);

  // ROM bus comes straight from pipeline stage 0 flops
  assign rom.IROM_EN = ~vld_pipe[0];
  assign rom.IROM_A  = addr_pipe[0];

  // Control FSM, address issue, capture pipeline and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vld_pipe  <= '0;
      addr_pipe <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
      end
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state        <= FETCH;
            vld_pipe[0]  <= 1'b1;
            addr_pipe[0] <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        FETCH: begin
          if (addr_pipe[0] == 6'd63) begin
            vld_pipe[0] <= 1'b0;        // address parks at 63
            state       <= DRAIN;
          end else begin
            addr_pipe[0] <= addr_pipe[0] + 6'd1;
          end
        end
        default: ;
      endcase
      // Last capture wins over the FETCH->DRAIN step (matters when RD_LAT=1)
      if (cap_last) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  // Buffer write at the capture edge; contents are never reset
  always_ff @(posedge clk) begin
    if (!reset && cap) mem[cap_addr] <= rom.IROM_Q;
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of captured bytes, restarted on every accepted start
  always_ff @(posedge clk) begin
    if (reset || launch) checksum <= '0;
    else if (cap)        checksum <= checksum + {8'd0, rom.IROM_Q};
  end
`else
  assign checksum = '0;
`endif

endmodule
